// File: rtl/pll_dyn_phase.sv
// ECP5 EHXPLLL wrapper: debounced lock, registered downstream reset and a dynamic
// phase-step sequencer. Define PLL_LOSS_COUNT_EN to count lock-loss events on loss_count.
module pll_dyn_phase #(
    parameter int CLKI_DIV      = 5,
    parameter int CLKFB_DIV     = 44,
    parameter int CLKOP_DIV     = 3,
    parameter int CLKOS_DIV     = 3,
    parameter int CLKOS2_DIV    = 3,
    parameter int CLKOS3_DIV    = 3,
    parameter int CLKOP_CPHASE  = 1,
    parameter int CLKOS_CPHASE  = 1,
    parameter int CLKOS2_CPHASE = 1,
    parameter int CLKOS3_CPHASE = 1,
    parameter int N_OUT         = 1,
    parameter int LOCK_CYCLES   = 1024,
    parameter int STEP_SETUP    = 2,
    parameter int STEP_LOW      = 4,
    parameter int STEP_HOLD     = 4
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] clkout,
    output logic       locked,
    output logic       rst_out,
    input  logic       ps_req,
    input  logic [1:0] ps_sel,
    input  logic       ps_dir,
    output logic       ps_ready,
    output logic       ps_done,
    output logic [7:0] loss_count
);

    localparam int LOCK_W   = $clog2(LOCK_CYCLES + 1);
    localparam int STEP_MAX = (STEP_SETUP > STEP_LOW)
                            ? ((STEP_SETUP > STEP_HOLD) ? STEP_SETUP : STEP_HOLD)
                            : ((STEP_LOW > STEP_HOLD) ? STEP_LOW : STEP_HOLD);
    localparam int STEP_W   = $clog2(STEP_MAX + 1);
    localparam logic [LOCK_W-1:0] LOCK_CNT_MAX = LOCK_W'(LOCK_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} seq_state_t;

    logic              pll_lock;
    logic              phaseloadreg;
    logic              lock_meta_q, lock_sync_q;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;
    logic              rst_out_q;

    seq_state_t        state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [1:0]        phasesel_q, phasesel_d;
    logic              phasedir_q, phasedir_d;
    logic              phasestep_q, phasestep_d;
    logic              ps_ready_q, ps_ready_d;
    logic              ps_done_q, ps_done_d;
    logic              sel_valid;

    assign phaseloadreg = 1'b1;

    // Lock debounce: any synchronised low sample restarts the count.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!lock_sync_q) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != LOCK_CNT_MAX) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
        locked_d = (lock_cnt_d == LOCK_CNT_MAX);
    end

    assign sel_valid = (int'(phasesel_q) < N_OUT);

    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        phasesel_d  = phasesel_q;
        phasedir_d  = phasedir_q;
        phasestep_d = phasestep_q;
        ps_done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ps_req && ps_ready_q) begin
                    phasesel_d = ps_sel;
                    phasedir_d = ps_dir;
                    step_cnt_d = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (step_cnt_q == STEP_W'(STEP_SETUP - 1)) begin
                    step_cnt_d  = '0;
                    state_d     = PULSE;
                    phasestep_d = !sel_valid;
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            PULSE: begin
                if (step_cnt_q == STEP_W'(STEP_LOW - 1)) begin
                    step_cnt_d  = '0;
                    state_d     = HOLD;
                    phasestep_d = 1'b1;
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (step_cnt_q == STEP_W'(STEP_HOLD - 1)) begin
                    step_cnt_d = '0;
                    state_d    = IDLE;
                    ps_done_d  = 1'b1;
                end else begin
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // The done cycle itself is not ready, so back-to-back accepts are latency+1 apart.
        ps_ready_d = (state_d == IDLE) && !ps_done_d && locked_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            rst_out_q   <= 1'b1;
            state_q     <= IDLE;
            step_cnt_q  <= '0;
            phasesel_q  <= 2'd0;
            phasedir_q  <= 1'b0;
            phasestep_q <= 1'b1;
            ps_ready_q  <= 1'b0;
            ps_done_q   <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_sync_q <= lock_meta_q;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            rst_out_q   <= !locked_q;
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            phasesel_q  <= phasesel_d;
            phasedir_q  <= phasedir_d;
            phasestep_q <= phasestep_d;
            ps_ready_q  <= ps_ready_d;
            ps_done_q   <= ps_done_d;
        end
    end

    assign locked   = locked_q;
    assign rst_out  = rst_out_q;
    assign ps_ready = ps_ready_q;
    assign ps_done  = ps_done_q;

`ifdef PLL_LOSS_COUNT_EN
    logic [7:0] loss_count_q, loss_count_d;

    always_comb begin
        loss_count_d = loss_count_q;
        if (locked_q && !locked_d && (loss_count_q != 8'hFF)) begin
            loss_count_d = loss_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            loss_count_q <= 8'd0;
        end else begin
            loss_count_q <= loss_count_d;
        end
    end

    assign loss_count = loss_count_q;
`else
    assign loss_count = 8'd0;
`endif

`ifdef SYNTHESIS
    logic [3:0] pll_clk;

    EHXPLLL #(
        .PLLRST_ENA      ("ENABLED"),
        .INTFB_WAKE      ("DISABLED"),
        .STDBY_ENABLE    ("DISABLED"),
        .DPHASE_SOURCE   ("ENABLED"),
        .FEEDBK_PATH     ("CLKOP"),
        .CLKI_DIV        (CLKI_DIV),
        .CLKFB_DIV       (CLKFB_DIV),
        .CLKOP_ENABLE    ("ENABLED"),
        .CLKOP_DIV       (CLKOP_DIV),
        .CLKOP_CPHASE    (CLKOP_CPHASE),
        .CLKOP_FPHASE    (0),
        .CLKOS_ENABLE    ((N_OUT > 1) ? "ENABLED" : "DISABLED"),
        .CLKOS_DIV       (CLKOS_DIV),
        .CLKOS_CPHASE    (CLKOS_CPHASE),
        .CLKOS_FPHASE    (0),
        .CLKOS2_ENABLE   ((N_OUT > 2) ? "ENABLED" : "DISABLED"),
        .CLKOS2_DIV      (CLKOS2_DIV),
        .CLKOS2_CPHASE   (CLKOS2_CPHASE),
        .CLKOS2_FPHASE   (0),
        .CLKOS3_ENABLE   ((N_OUT > 3) ? "ENABLED" : "DISABLED"),
        .CLKOS3_DIV      (CLKOS3_DIV),
        .CLKOS3_CPHASE   (CLKOS3_CPHASE),
        .CLKOS3_FPHASE   (0)
    ) u_pll (
        .CLKI         (clock),
        .CLKFB        (pll_clk[0]),
        .RST          (reset),
        .STDBY        (1'b0),
        .PHASESEL1    (phasesel_q[1]),
        .PHASESEL0    (phasesel_q[0]),
        .PHASEDIR     (phasedir_q),
        .PHASESTEP    (phasestep_q),
        .PHASELOADREG (phaseloadreg),
        .PLLWAKESYNC  (1'b0),
        .ENCLKOP      (1'b1),
        .ENCLKOS      (1'b1),
        .ENCLKOS2     (1'b1),
        .ENCLKOS3     (1'b1),
        .CLKOP        (pll_clk[0]),
        .CLKOS        (pll_clk[1]),
        .CLKOS2       (pll_clk[2]),
        .CLKOS3       (pll_clk[3]),
        .LOCK         (pll_lock),
        .INTLOCK      (),
        .REFCLK       (),
        .CLKINTFB     ()
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_out
        if (gi < N_OUT) begin : g_en
            assign clkout[gi] = pll_clk[gi];
        end else begin : g_dis
            assign clkout[gi] = 1'b0;
        end
    end
`else
    // Behavioural stand-in: lock after CLKI_DIV*CLKFB_DIV cycles, outputs are board-clock
    // dividers that slip (lag) or skip (lead) one count per phase step.
    localparam int OUT_DIV [4]    = '{CLKOP_DIV, CLKOS_DIV, CLKOS2_DIV, CLKOS3_DIV};
    localparam int OUT_CPHASE [4] = '{CLKOP_CPHASE, CLKOS_CPHASE, CLKOS2_CPHASE, CLKOS3_CPHASE};
    localparam int SIM_LOCK_DLY   = CLKI_DIV * CLKFB_DIV;
    localparam int SIM_LW         = $clog2(SIM_LOCK_DLY + 1);

    logic [SIM_LW-1:0] sim_lock_cnt_q;
    logic              sim_lock_q;
    logic              phasestep_prev_q;
    logic              step_evt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sim_lock_cnt_q   <= '0;
            sim_lock_q       <= 1'b0;
            phasestep_prev_q <= 1'b1;
        end else begin
            phasestep_prev_q <= phasestep_q;
            if (sim_lock_cnt_q == SIM_LW'(SIM_LOCK_DLY)) begin
                sim_lock_q <= 1'b1;
            end else begin
                sim_lock_cnt_q <= sim_lock_cnt_q + 1'b1;
            end
        end
    end

    assign pll_lock = sim_lock_q;
    assign step_evt = phaseloadreg && phasestep_prev_q && !phasestep_q;

    for (genvar gi = 0; gi < 4; gi++) begin : g_out
        if (gi < N_OUT) begin : g_en
            logic [7:0] div_cnt_q;
            logic       clk_q;
            logic       hit;
            int         div_nxt;

            assign hit = step_evt && (phasesel_q == 2'(gi));

            always_comb begin
                div_nxt = int'(div_cnt_q) + ((hit && phasedir_q) ? 2 : 1);
            end

            always_ff @(posedge clock) begin
                if (reset || !pll_lock) begin
                    div_cnt_q <= 8'(OUT_CPHASE[gi] % OUT_DIV[gi]);
                    clk_q     <= 1'b0;
                end else if (!(hit && !phasedir_q)) begin
                    if (div_nxt >= OUT_DIV[gi]) begin
                        div_cnt_q <= 8'(div_nxt - OUT_DIV[gi]);
                        clk_q     <= ~clk_q;
                    end else begin
                        div_cnt_q <= 8'(div_nxt);
                    end
                end
            end

            assign clkout[gi] = clk_q;
        end else begin : g_dis
            assign clkout[gi] = 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pll_dyn_phase.sv
// Bench for pll_dyn_phase: lock debounce, glitches, phase-step timing, reset abort, loss count.
module tb_pll_dyn_phase;
    localparam int N_OUT_TB = 2;
    localparam int LOCK_TB  = 16;
    localparam int LAT      = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps_req = 1'b0;
    logic [1:0] ps_sel = 2'd0;
    logic       ps_dir = 1'b0;
    logic [3:0] clkout;
    logic       locked, rst_out, ps_ready, ps_done;
    logic [7:0] loss_count;

    pll_dyn_phase #(
        .N_OUT       (N_OUT_TB),
        .LOCK_CYCLES (LOCK_TB)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .clkout     (clkout),
        .locked     (locked),
        .rst_out    (rst_out),
        .ps_req     (ps_req),
        .ps_sel     (ps_sel),
        .ps_dir     (ps_dir),
        .ps_ready   (ps_ready),
        .ps_done    (ps_done),
        .loss_count (loss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int s;
        int sel;
        int dir;
    } step_exp_t;

    step_exp_t sb[$];
    bit mon_en   = 1'b0;
    bit burst    = 1'b0;
    int last_acc = -1;
    int acc_cnt  = 0;
    int mon_k;
    bit is_locked = 1'b0;
    int exp_loss  = 0;

    // Scoreboard: accepts are pushed as they are seen, checked cycle by cycle until ps_done.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0) begin
                mon_k = cyc - sb[0].s;
                if (mon_k >= 1 && mon_k <= LAT) begin
                    if (mon_k == 1) begin
                        check_eq("phasesel", int'(dut.phasesel_q), sb[0].sel);
                        check_eq("phasedir", int'(dut.phasedir_q), sb[0].dir);
                    end
                    check_eq("phasestep", int'(dut.phasestep_q),
                             (mon_k >= 3 && mon_k <= 6 && sb[0].sel < N_OUT_TB) ? 0 : 1);
                    check_eq("ps_ready_busy", int'(ps_ready), 0);
                    check_eq("ps_done", int'(ps_done), (mon_k == LAT) ? 1 : 0);
                    if (mon_k == LAT) void'(sb.pop_front());
                end
            end else begin
                check_eq("phasestep_idle", int'(dut.phasestep_q), 1);
                check_eq("ps_done_idle", int'(ps_done), 0);
            end
            check_eq("clkout_disabled", int'(clkout[3:2]), 0);
            if (ps_req && ps_ready) begin
                if (burst && last_acc >= 0) check_eq("b2b_spacing", cyc - last_acc, LAT + 1);
                last_acc = cyc;
                acc_cnt++;
                sb.push_back('{s: cyc, sel: int'(ps_sel), dir: int'(ps_dir)});
            end
        end
    end

    task automatic drive_sync();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_neg(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_lock(input bit v);
        if (v) force dut.pll_lock = 1'b1;
        else   force dut.pll_lock = 1'b0;
    endtask

    task automatic relock(input int e1);
        wait_neg(e1 + LOCK_TB);
        check_eq("lock_early", int'(locked), 0);
        check_eq("rst_out_held", int'(rst_out), 1);
        wait_neg(e1 + LOCK_TB + 1);
        check_eq("lock_rise", int'(locked), 1);
        check_eq("ready_on_lock", int'(ps_ready), 1);
        wait_neg(e1 + LOCK_TB + 2);
        check_eq("rst_out_release", int'(rst_out), 0);
        is_locked = 1'b1;
    endtask

    task automatic glitch(input bit finish);
        int e1;
        drive_sync();
        set_lock(1'b0);
`ifdef PLL_LOSS_COUNT_EN
        if (is_locked && exp_loss < 255) exp_loss++;
`endif
        is_locked = 1'b0;
        drive_sync();
        set_lock(1'b1);
        e1 = cyc + 1;
        wait_neg(e1 + 1);
        check_eq("lock_drop", int'(locked), 0);
        if (finish) relock(e1);
        else wait_neg(e1 + 9);
    endtask

    task automatic do_step(input int sel, input int dir, input int exp_ready);
        int s;
        drive_sync();
        ps_req = 1'b1;
        ps_sel = 2'(sel);
        ps_dir = dir[0];
        drive_sync();
        ps_req = 1'b0;
        check_eq("accepted", sb.size(), 1);
        if (sb.size() > 0) begin
            s = sb[0].s;
            wait_neg(s + LAT + 1);
            check_eq("sb_drain", sb.size(), 0);
            check_eq("ready_after_done", int'(ps_ready), exp_ready);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        int s;
        int acc0;
        set_lock(1'b0);
        repeat (4) drive_sync();
        wait_neg(cyc);
        check_eq("rst_locked", int'(locked), 0);
        check_eq("rst_rst_out", int'(rst_out), 1);
        check_eq("rst_ps_ready", int'(ps_ready), 0);
        check_eq("rst_ps_done", int'(ps_done), 0);
        check_eq("rst_loss", int'(loss_count), 0);
        check_eq("rst_phasestep", int'(dut.phasestep_q), 1);
        check_eq("rst_phasesel", int'(dut.phasesel_q), 0);
        check_eq("rst_phasedir", int'(dut.phasedir_q), 0);

        drive_sync();
        reset = 1'b0;
        repeat (5) drive_sync();
        check_eq("no_lock_yet", int'(locked), 0);
        set_lock(1'b1);
        relock(cyc + 1);
        mon_en = 1'b1;

        wait_neg(cyc + 1);
        c0 = int'(clkout[0]);
        wait_neg(cyc + 3);
        check_eq("clkop_toggle", int'(clkout[0]), c0 ^ 1);

        glitch(1'b0);
        glitch(1'b1);
        check_eq("loss_after_1", int'(loss_count), exp_loss);

        do_step(1, 1, 1);
        do_step(3, 0, 1);
        do_step(0, 0, 1);

        drive_sync();
        burst = 1'b1;
        last_acc = -1;
        acc0 = acc_cnt;
        ps_req = 1'b1;
        ps_sel = 2'd1;
        ps_dir = 1'b0;
        c0 = cyc;
        repeat (37) drive_sync();
        ps_req = 1'b0;
        wait_neg(c0 + 3 * (LAT + 1) + LAT + 1);
        burst = 1'b0;
        check_eq("b2b_count", acc_cnt - acc0, 4);

        fork
            do_step(1, 0, 0);
            begin
                drive_sync();
                drive_sync();
                glitch(1'b1);
            end
        join
        glitch(1'b1);
        check_eq("loss_after_3", int'(loss_count), exp_loss);

        drive_sync();
        ps_req = 1'b1;
        ps_sel = 2'd0;
        ps_dir = 1'b0;
        drive_sync();
        ps_req = 1'b0;
        check_eq("rst_step_accepted", sb.size(), 1);
        s = (sb.size() > 0) ? sb[0].s : cyc;
        wait_neg(s + 4);
        check_eq("pulse_before_rst", int'(dut.phasestep_q), 0);
        drive_sync();
        mon_en = 1'b0;
        sb.delete();
        reset = 1'b1;
        is_locked = 1'b0;
        exp_loss = 0;
        wait_neg(s + 6);
        check_eq("abort_phasestep", int'(dut.phasestep_q), 1);
        check_eq("abort_ps_ready", int'(ps_ready), 0);
        check_eq("abort_locked", int'(locked), 0);
        check_eq("abort_phasesel", int'(dut.phasesel_q), 0);
        drive_sync();
        reset = 1'b0;
        relock(cyc + 1);
        mon_en = 1'b1;
        check_eq("loss_after_reset", int'(loss_count), exp_loss);

        for (int i = 0; i < 300; i++) glitch(1'b1);
        check_eq("loss_saturate", int'(loss_count), exp_loss);
        do_step(1, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pll_dyn_phase.md
Name: pll_dyn_phase

Overview:
- Parametrised ECP5 EHXPLLL wrapper with up to four outputs (CLKOP, CLKOS, CLKOS2, CLKOS3), each with its own divider and static phase.
- Adds behaviour a fixed-frequency PLL wrapper lacks:
  - debounced lock output;
  - synchronous reset release for downstream logic;
  - a handshake-driven dynamic phase-step sequencer on PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG.
- Sits at the top of board designs, between the 25 MHz board oscillator and all generated clock domains (e.g. SDRAM clock phase tuning).

Parameters:
- CLKI_DIV, 5, input divider.
- CLKFB_DIV, 44, feedback divider. Feedback path is fixed to CLKOP.
- CLKOP_DIV, 3, CLKOP output divider.
- CLKOS_DIV, 3, CLKOS output divider.
- CLKOS2_DIV, 3, CLKOS2 output divider.
- CLKOS3_DIV, 3, CLKOS3 output divider.
- CLKOP_CPHASE / CLKOS_CPHASE / CLKOS2_CPHASE / CLKOS3_CPHASE, 1, coarse static phase per output.
- N_OUT, 1, number of enabled outputs (1..4). Outputs at index >= N_OUT are disabled and drive 0.
- LOCK_CYCLES, 1024, consecutive synchronised-lock cycles required before locked asserts. Minimum 2.
- STEP_SETUP, 2, cycles PHASESEL/PHASEDIR are held stable before the step pulse.
- STEP_LOW, 4, width in cycles of the PHASESTEP low pulse.
- STEP_HOLD, 4, cycles after the pulse before the next request is accepted.

Ports:
- clock, in, 1, board clock (25 MHz). Feeds CLKI and all control logic.
- reset, in, 1, synchronous, active-high. Drives PLL RST high while asserted.
- clkout, out, 4, bit i = output i (0=CLKOP … 3=CLKOS3). Bits >= N_OUT are 0.
- locked, out, 1, debounced lock.
- rst_out, out, 1, active-high reset for downstream domains. Equals !locked, registered.
- ps_req, in, 1, phase-step request. Sampled when ps_ready=1.
- ps_sel, in, 2, output to step (0..3).
- ps_dir, in, 1, 0 = delay (lag), 1 = advance (lead).
- ps_ready, out, 1, sequencer can accept a request.
- ps_done, out, 1, one-cycle pulse when a step completes.
- loss_count, out, 8, lock-loss events (see Optional Feature).

Behaviour:
- Reset values: locked=0, rst_out=1, ps_ready=0, ps_done=0, loss_count=0. PHASESTEP=1, PHASELOADREG=1, PHASESEL=0, PHASEDIR=0. Sequencer state = IDLE. Lock counter = 0.
- Lock path:
  - PLL LOCK passes through a 2-FF synchroniser into the clock domain.
  - Counter increments while the synchronised lock is 1 and saturates at LOCK_CYCLES. locked=1 when count == LOCK_CYCLES.
  - Synchronised lock = 0 clears the counter and drops locked on the next cycle. No debounce on loss.
  - rst_out = !locked, registered. Therefore rst_out deasserts 1 cycle after locked rises.
- Sequencer states: IDLE, SETUP, PULSE, HOLD.
  - IDLE: ps_ready = locked. If ps_req && ps_ready: latch ps_sel and ps_dir onto PHASESEL/PHASEDIR, go to SETUP, ps_ready=0 from the next cycle.
  - SETUP: hold for STEP_SETUP cycles, then go to PULSE.
  - PULSE: PHASESTEP=0 for STEP_LOW cycles. Return PHASESTEP to 1 and go to HOLD.
  - HOLD: wait STEP_HOLD cycles. Pulse ps_done for 1 cycle. Go to IDLE.
- Latency: request accept to ps_done = STEP_SETUP+STEP_LOW+STEP_HOLD+1 cycles (11 at defaults).
- ps_sel >= N_OUT: the request is accepted and the full sequence runs, but PHASESTEP stays 1 (no-op). ps_done still pulses.
- Loss of lock mid-step: sequence runs to completion with unchanged timing. ps_ready stays 0 until locked reasserts.
- reset mid-step: abort immediately to reset values. PHASESTEP returns to 1 the cycle after reset is sampled.
- ps_req held high continuously: one step per accept. Back-to-back accept spacing = latency + 1 cycle.
- Counters are sized by $clog2 of their parameter, with no overflow or wrap.

Optional Feature:
- Macro: PLL_LOSS_COUNT_EN.
- Defined:
  - loss_count is an 8-bit saturating counter (max 255).
  - Increments on each locked 1→0 transition not caused by reset.
  - Cleared only by reset.
- Undefined: loss_count is tied to 0 and no counter logic is generated.

Test Plan:
- Lock debounce: reset 4 cycles, model LOCK rising at cycle 10, LOCK_CYCLES=16 → locked=1 at cycle 10+2+16; rst_out=0 one cycle later.
- Lock glitch: LOCK low for 1 cycle at count 8 → counter clears; locked delayed to 16 cycles after LOCK returns. Glitch after lock → locked=0 within 3 cycles.
- Phase step: locked, ps_req=1, ps_sel=1, ps_dir=1 → PHASESEL=1 and PHASEDIR=1 from the next cycle; PHASESTEP low for exactly 4 cycles starting 2 cycles later; ps_done high 11 cycles after accept; ps_ready=1 next cycle.
- Out-of-range select: N_OUT=2, ps_sel=3 → PHASESTEP never goes low; ps_done after 11 cycles.
- Reset mid-PULSE: assert reset during PHASESTEP=0 → PHASESTEP=1, ps_ready=0, locked=0 the next cycle.
- With PLL_LOSS_COUNT_EN: drop LOCK 3 times after lock → loss_count=3. 300 drops → loss_count=255. Without the macro → loss_count=0 throughout.
